// File: rtl/fpu_mul_sched_pkg.sv
// Shared types for the FP multiply scheduler: port identifiers and per-stage metadata.
// Tags are stored at a fixed maximum width; the top narrows them to its TAG_W.
package fpu_mul_sched_pkg;

  localparam int MUL_LATENCY = 3;
  localparam int TAG_W_MAX   = 8;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  typedef struct packed {
    logic                 valid;
    port_t                port;
    logic [TAG_W_MAX-1:0] tag;
  } stage_meta_t;

endpackage

// File: rtl/fpu_mul_sched_arb.sv
// Two-input round-robin arbiter, zero-cycle grant; the pointer flips to the losing port on each accepted grant.
// Grants assert only while advance is high, so a stalled or flushed cycle leaves the pointer untouched.
module rr_arb2
  import fpu_mul_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output port_t      gnt_idx
);

  port_t rr_q;
  port_t rr_d;

  always_comb begin
    gnt_idx = PORT0;
    if (req[1] && (!req[0] || rr_q == PORT1)) begin
      gnt_idx = PORT1;
    end
    gnt[0] = advance && req[0] && (gnt_idx == PORT0);
    gnt[1] = advance && req[1] && (gnt_idx == PORT1);
    rr_d   = rr_q;
    if (|gnt) begin
      rr_d = (gnt_idx == PORT0) ? PORT1 : PORT0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= PORT0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/fpu_mul_sched.sv
// Two-port scheduler for the 3-stage FP multiply pipeline; a handshake in cycle N yields res_valid in N+3.
// res_ready ripples combinationally through the stage advance chain into req*_ready; bubbles collapse.
module fpu_mul_sched
  import fpu_mul_sched_pkg::*;
#(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req0_valid,
  input  logic [31:0]      req0_fp1,
  input  logic [31:0]      req0_fp2,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_fp1,
  input  logic [31:0]      req1_fp2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic [31:0]      mul_fp1,
  output logic [31:0]      mul_fp2,
  output logic             s1_en,
  output logic             s2_en,
  output logic             s3_en,
  output logic             res_valid,
  output logic             res_port,
  output logic [TAG_W-1:0] res_tag,
  input  logic             res_ready
);

  stage_meta_t meta1_q, meta1_d;
  stage_meta_t meta2_q, meta2_d;
  stage_meta_t meta3_q, meta3_d;

  logic       adv1, adv2, adv3;
  logic       accept_en;
  logic [1:0] gnt;
  port_t      gnt_idx;

  assign adv3      = !meta3_q.valid || res_ready;
  assign adv2      = !meta2_q.valid || adv3;
  assign adv1      = !meta1_q.valid || adv2;
  assign accept_en = adv1 && !flush && !reset;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .advance (accept_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    meta1_d = meta1_q;
    meta2_d = meta2_q;
    meta3_d = meta3_q;
    if (adv1) begin
      meta1_d.valid = |gnt;
      meta1_d.port  = gnt_idx;
      meta1_d.tag   = TAG_W_MAX'((gnt_idx == PORT1) ? req1_tag : req0_tag);
    end
    if (adv2) begin
      meta2_d = meta1_q;
    end
    if (adv3) begin
      meta3_d = meta2_q;
    end
    // Flush kills validity only; payload is left to be overwritten.
    if (flush) begin
      meta1_d.valid = 1'b0;
      meta2_d.valid = 1'b0;
      meta3_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta1_q <= '0;
      meta2_q <= '0;
      meta3_q <= '0;
    end else begin
      meta1_q <= meta1_d;
      meta2_q <= meta2_d;
      meta3_q <= meta3_d;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign mul_fp1    = gnt[1] ? req1_fp1 : req0_fp1;
  assign mul_fp2    = gnt[1] ? req1_fp2 : req0_fp2;
  assign s1_en      = adv1;
  assign s2_en      = adv2;
  assign s3_en      = adv3;
  assign res_valid  = meta3_q.valid;
  assign res_port   = meta3_q.port;
  assign res_tag    = meta3_q.tag[TAG_W-1:0];

  if (TAG_W < TAG_W_MAX) begin : g_tag_pad
    logic unused_tag_hi;
    assign unused_tag_hi = ^meta3_q.tag[TAG_W_MAX-1:TAG_W];
  end

endmodule

// File: tb/tb_fpu_mul_sched.sv
// Directed bench for fpu_mul_sched: inputs change 1ns after posedge, outputs are sampled 2ns later.
// Cycle 0 of each scenario is the first cycle with reset low.
module tb_fpu_mul_sched;
  import fpu_mul_sched_pkg::*;

  localparam int TAG_W = 3;
  localparam logic [31:0] FP0_A = 32'h3f80_0000;
  localparam logic [31:0] FP0_B = 32'h4040_0000;
  localparam logic [31:0] FP1_A = 32'h4000_0000;
  localparam logic [31:0] FP1_B = 32'hc0a0_0000;

  logic             clk = 1'b0;
  logic             reset, flush, res_ready;
  logic             req0_valid, req1_valid;
  logic [31:0]      req0_fp1, req0_fp2, req1_fp1, req1_fp2;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             req0_ready, req1_ready;
  logic [31:0]      mul_fp1, mul_fp2;
  logic             s1_en, s2_en, s3_en;
  logic             res_valid, res_port;
  logic [TAG_W-1:0] res_tag;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpu_mul_sched #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_fp1   (req0_fp1),
    .req0_fp2   (req0_fp2),
    .req0_tag   (req0_tag),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_fp1   (req1_fp1),
    .req1_fp2   (req1_fp2),
    .req1_tag   (req1_tag),
    .req1_ready (req1_ready),
    .mul_fp1    (mul_fp1),
    .mul_fp2    (mul_fp2),
    .s1_en      (s1_en),
    .s2_en      (s2_en),
    .s3_en      (s3_en),
    .res_valid  (res_valid),
    .res_port   (res_port),
    .res_tag    (res_tag),
    .res_ready  (res_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    flush      = 1'b0;
    res_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_tag   = '0;
    req1_tag   = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  logic [TAG_W-1:0] ct_tag [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
  int               nacc;
  logic             exp_rdy;

  initial begin
    req0_fp1 = FP0_A; req0_fp2 = FP0_B;
    req1_fp1 = FP1_A; req1_fp2 = FP1_B;

    // Reset values, sampled while reset is still asserted.
    do_reset();
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    check("rst_rdy0", req0_ready, 1'b0);
    check("rst_rdy1", req1_ready, 1'b0);
    check("rst_s1en", s1_en, 1'b1);
    check("rst_s2en", s2_en, 1'b1);
    check("rst_s3en", s3_en, 1'b1);
    check("rst_vld",  res_valid, 1'b0);
    check("rst_port", res_port, 1'b0);
    check("rst_tag",  res_tag, 3'd0);
    check("rst_fp1",  mul_fp1, FP0_A);
    check("rst_fp2",  mul_fp2, FP0_B);

    // Single op, tag 5 on port 0.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req0_valid = (c == 0);
      req0_tag   = 3'd5;
      #2;
      if (c == 0) begin
        check("so_rdy0", req0_ready, 1'b1);
        check("so_rdy1", req1_ready, 1'b0);
      end
      check("so_vld", res_valid, (c == 3));
      if (c == 3) begin
        check("so_port", res_port, 1'b0);
        check("so_tag",  res_tag, 3'd5);
      end
      next_cycle();
    end

    // Contention: both ports valid cycles 0-3, round-robin P0,P1,P0,P1.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req0_valid = (c < 4);
      req1_valid = (c < 4);
      req0_tag   = (c < 1) ? 3'd1 : 3'd2;
      req1_tag   = (c < 2) ? 3'd3 : 3'd4;
      #2;
      if (c < 4) begin
        check("ct_rdy0", req0_ready, (c % 2 == 0));
        check("ct_rdy1", req1_ready, (c % 2 == 1));
        check("ct_fp1",  mul_fp1, (c % 2 == 0) ? FP0_A : FP1_A);
        check("ct_fp2",  mul_fp2, (c % 2 == 0) ? FP0_B : FP1_B);
      end
      check("ct_vld", res_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        check("ct_tag",  res_tag, ct_tag[c-3]);
        check("ct_port", res_port, ((c - 3) % 2 == 1));
      end
      next_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Back-pressure: port 1 stream, consumer stalls cycles 3-7.
    do_reset();
    nacc = 0;
    for (int c = 0; c < 14; c++) begin
      req1_valid = (c < 10);
      req1_tag   = 3'(nacc);
      res_ready  = !(c >= 3 && c <= 7);
      #2;
      exp_rdy = (c < 3) || (c == 8) || (c == 9);
      if (c < 10) check("bp_rdy1", req1_ready, exp_rdy);
      if (c >= 3 && c <= 8) begin
        check("bp_s1en", s1_en, (c == 8));
        check("bp_s2en", s2_en, (c == 8));
        check("bp_s3en", s3_en, (c == 8));
      end
      check("bp_vld", res_valid, (c >= 3 && c <= 12));
      if (c >= 3 && c <= 12) begin
        check("bp_tag",  res_tag, (c <= 8) ? 3'd0 : 3'(c - 8));
        check("bp_port", res_port, 1'b1);
      end
      if (c < 10 && exp_rdy) nacc++;
      next_cycle();
    end
    req1_valid = 1'b0;
    res_ready  = 1'b1;

    // Bubble collapse: accepts in cycles 0 and 2, consumer stalls cycles 3-5.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req0_valid = (c == 0) || (c == 2) || (c == 5);
      req0_tag   = (c == 0) ? 3'd1 : ((c == 2) ? 3'd2 : 3'd3);
      res_ready  = !(c >= 3 && c <= 5);
      #2;
      if (c == 5) begin
        check("bc_rdy0", req0_ready, 1'b1);
        check("bc_s1en", s1_en, 1'b1);
        check("bc_s2en", s2_en, 1'b0);
        check("bc_s3en", s3_en, 1'b0);
        check("bc_v1",   dut.meta1_q.valid, 1'b0);
        check("bc_v2",   dut.meta2_q.valid, 1'b1);
        check("bc_v3",   dut.meta3_q.valid, 1'b1);
      end
      check("bc_vld", res_valid, (c >= 3 && c <= 8));
      if (c >= 3 && c <= 8) check("bc_tag", res_tag, (c <= 6) ? 3'd1 : 3'(c - 5));
      next_cycle();
    end
    req0_valid = 1'b0;
    res_ready  = 1'b1;

    // Flush in cycle 2 with a request pending; the request is taken in cycle 3 instead.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req0_valid = (c <= 3);
      req0_tag   = (c == 0) ? 3'd1 : ((c == 1) ? 3'd2 : 3'd3);
      flush      = (c == 2);
      #2;
      if (c <= 3) check("fl_rdy0", req0_ready, (c != 2));
      check("fl_vld", res_valid, (c == 6));
      if (c == 6) check("fl_tag", res_tag, 3'd3);
      next_cycle();
    end
    req0_valid = 1'b0;
    flush      = 1'b0;

    // Reset mid-stream: pointer left at port 1 by a contention win, then reset in cycle 2.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      reset      = (c == 2);
      req0_valid = (c == 0) || (c == 2) || (c == 6);
      req1_valid = (c == 0) || (c == 2) || (c == 6);
      req0_tag   = 3'd6;
      req1_tag   = 3'd7;
      #2;
      if (c == 0 || c == 2 || c == 6) begin
        check("rm_rdy0", req0_ready, (c != 2));
        check("rm_rdy1", req1_ready, 1'b0);
      end
      if (c >= 2 && c <= 7) check("rm_vld", res_valid, 1'b0);
      next_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
